lbp_stream_engine: RTL

//  Parametrised streaming LBP (local binary pattern) engine; successor to the fixed 128x128 fetch-per-neighbour LBP.

---
 rtl/lbp_pkg.sv | 39 +++
 rtl/lbp_line_buffer.sv | 36 +++
 rtl/lbp_stream_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lbp_pkg.sv
// Shared definitions for the streaming LBP engine.
// Holds the FSM state type, the neighbour bit weights and the
// rotation-invariant uniform (riu2) encoder.
package lbp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } lbp_state_e;

  // Bit weight of each neighbour in the basic 8-bit code
  localparam logic [7:0] WeightTl = 8'd1;
  localparam logic [7:0] WeightT  = 8'd2;
  localparam logic [7:0] WeightTr = 8'd4;
  localparam logic [7:0] WeightL  = 8'd8;
  localparam logic [7:0] WeightR  = 8'd16;
  localparam logic [7:0] WeightBl = 8'd32;
  localparam logic [7:0] WeightB  = 8'd64;
  localparam logic [7:0] WeightBr = 8'd128;

  // Maps a basic code to riu2: popcount when the circular pattern has at most
  // two 0/1 transitions, otherwise 9. Circle order is TL,T,TR,R,BR,B,BL,L.
  function automatic logic [7:0] riu2_code(input logic [7:0] code);
    logic [7:0] circ;
    logic [3:0] ones;
    logic [3:0] trans;
    circ  = {code[3], code[5], code[6], code[7], code[4], code[2], code[1], code[0]};
    ones  = 4'd0;
    trans = 4'd0;
    for (int k = 0; k < 8; k++) begin
      ones  = ones + {3'b000, circ[k]};
      trans = trans + {3'b000, circ[k] ^ circ[(k + 1) % 8]};
    end
    return (trans <= 4'd2) ? {4'b0000, ones} : 8'd9;
  endfunction

endpackage

// File: rtl/lbp_line_buffer.sv
// Two-row pixel delay line for the LBP window.
// Ports:
//   clk_i   clock
//   adv_i   advance: write din_i at col_i and shift the old row-1 pixel into row 2
//   col_i   current raster column
//   din_i   incoming pixel (current row)
//   row1_o  pixel one row above at col_i (value before this advance)
//   row2_o  pixel two rows above at col_i (value before this advance)
// Contents are not reset; the top only uses them once two rows have passed.
module lbp_line_buffer #(
  parameter int unsigned ImgW = 128,
  parameter int unsigned PixW = 8,
  parameter int unsigned ColW = $clog2(ImgW)
) (
  input  logic            clk_i,
  input  logic            adv_i,
  input  logic [ColW-1:0] col_i,
  input  logic [PixW-1:0] din_i,
  output logic [PixW-1:0] row1_o,
  output logic [PixW-1:0] row2_o
);

  logic [PixW-1:0] row1_mem [ImgW];
  logic [PixW-1:0] row2_mem [ImgW];

  assign row1_o = row1_mem[col_i];
  assign row2_o = row2_mem[col_i];

  always_ff @(posedge clk_i) begin
    if (adv_i) begin
      row2_mem[col_i] <= row1_mem[col_i];
      row1_mem[col_i] <= din_i;
    end
  end

endmodule

// File: rtl/lbp_stream_engine.sv
// Streaming LBP engine: reads the grey image once in raster order, keeps two
// line buffers and a 3x3 window, and writes one code per pixel (borders = 0).
// Ports:
//   clk, reset            clock, async active-high reset
//   mode                  0 = basic 8-bit LBP, 1 = riu2; latched at frame start
//   gray_ready/req/addr/data  source read interface (data valid with req)
//   lbp_valid/addr/data   result write interface
//   finish                frame complete (held until reset)
module lbp_stream_engine
  import lbp_pkg::*;
#(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [AW-1:0] LastAddr  = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] FirstEmit = AW'(IMG_W + 1);
  localparam logic [CW-1:0] LastCol   = CW'(IMG_W - 1);

  lbp_state_e state_q, state_d;
  logic                mode_q, mode_d;
  logic [AW-1:0]       gray_addr_q, gray_addr_d;
  logic [AW-1:0]       emit_cnt_q, emit_cnt_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  // [0] = column c-1, [1] = column c-2 relative to the incoming pixel
  logic [1:0][DW-1:0]  win_top_q, win_top_d;
  logic [1:0][DW-1:0]  win_mid_q, win_mid_d;
  logic [1:0][DW-1:0]  win_bot_q, win_bot_d;
  logic                lbp_valid_q, lbp_valid_d;
  logic [AW-1:0]       lbp_addr_q, lbp_addr_d;
  logic [7:0]          lbp_data_q, lbp_data_d;

  logic          capture;
  logic          interior;
  logic [DW-1:0] lb_row1, lb_row2;
  logic [DW-1:0] center;
  logic [7:0]    basic_code;
  logic [7:0]    code;

  lbp_line_buffer #(
    .ImgW (IMG_W),
    .PixW (DW),
    .ColW (CW)
  ) u_line_buffer (
    .clk_i  (clk),
    .adv_i  (capture),
    .col_i  (col_q),
    .din_i  (gray_data),
    .row1_o (lb_row1),
    .row2_o (lb_row2)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gray_ready) state_d = StFetch;
      StFetch: if (capture && (gray_addr_q == LastAddr)) state_d = StDrain;
      StDrain: if (emit_cnt_q == LastAddr) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gray_req = (state_q == StFetch) && gray_ready;
    // The first DONE cycle still carries the final drain write.
    finish   = (state_q == StDone) && !lbp_valid_q;
  end

  assign capture = gray_req;

  // ---------------- Encode ----------------
  // Window centre is one row up and one column left of the incoming pixel; it
  // is interior exactly when the incoming pixel sits at row >= 2 and col >= 2.
  // Lower columns wrap onto the previous row but then the centre is a border.
  assign interior = (col_q >= CW'(2)) && (row_q >= RW'(2));
  assign center   = win_mid_q[0];

  always_comb begin
    basic_code = 8'd0;
    if (win_top_q[1] >= center) basic_code = basic_code | WeightTl;
    if (win_top_q[0] >= center) basic_code = basic_code | WeightT;
    if (lb_row2      >= center) basic_code = basic_code | WeightTr;
    if (win_mid_q[1] >= center) basic_code = basic_code | WeightL;
    if (lb_row1      >= center) basic_code = basic_code | WeightR;
    if (win_bot_q[1] >= center) basic_code = basic_code | WeightBl;
    if (win_bot_q[0] >= center) basic_code = basic_code | WeightB;
    if (gray_data    >= center) basic_code = basic_code | WeightBr;
    code = mode_q ? riu2_code(basic_code) : basic_code;
  end

  // ---------------- Datapath next state ----------------
  always_comb begin
    mode_d      = mode_q;
    gray_addr_d = gray_addr_q;
    emit_cnt_d  = emit_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    win_top_d   = win_top_q;
    win_mid_d   = win_mid_q;
    win_bot_d   = win_bot_q;
    lbp_valid_d = 1'b0;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = 8'd0;

    if ((state_q == StIdle) && gray_ready) mode_d = mode;

    if (capture) begin
      if (gray_addr_q != LastAddr) gray_addr_d = gray_addr_q + AW'(1);
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      win_top_d = {win_top_q[0], lb_row2};
      win_mid_d = {win_mid_q[0], lb_row1};
      win_bot_d = {win_bot_q[0], gray_data};
      if (gray_addr_q >= FirstEmit) begin
        lbp_valid_d = 1'b1;
        lbp_addr_d  = emit_cnt_q;
        lbp_data_d  = interior ? code : 8'd0;
        emit_cnt_d  = emit_cnt_q + AW'(1);
      end
    end

    // Trailing addresses are the last column of row H-2 and all of row H-1.
    if (state_q == StDrain) begin
      lbp_valid_d = 1'b1;
      lbp_addr_d  = emit_cnt_q;
      emit_cnt_d  = emit_cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= 1'b0;
      gray_addr_q <= '0;
      emit_cnt_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
      win_top_q   <= '0;
      win_mid_q   <= '0;
      win_bot_q   <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= 8'd0;
    end else begin
      mode_q      <= mode_d;
      gray_addr_q <= gray_addr_d;
      emit_cnt_q  <= emit_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_top_q   <= win_top_d;
      win_mid_q   <= win_mid_d;
      win_bot_q   <= win_bot_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
    end
  end

  assign gray_addr = gray_addr_q;
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;

endmodule
